// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file writeback commit arbiter.
package wb_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_ZERO = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; DEPTH must be a power of two (>= 2).
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = wb_entry_t,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  entry_t           wdata_i,
    input  logic             pop_i,
    output entry_t           rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_en, pop_en;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];

    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        rd_d  = rd_q + PTR_W'(pop_en);
        wr_d  = wr_q + PTR_W'(push_en);
        cnt_d = cnt_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/wb_commit_arb.sv
// Register-file write-port arbiter: pipeline writeback first, buffered multi-cycle results
// otherwise. Define WB_BYPASS_EN to let an mc result skip an empty FIFO in the same cycle.
module wb_commit_arb #(
    parameter int unsigned ADDR_W       = wb_pkg::ADDR_W,
    parameter int unsigned DATA_W       = wb_pkg::DATA_W,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   pipe_we,
    input  logic [ADDR_W-1:0]      pipe_addr,
    input  logic [DATA_W-1:0]      pipe_data,
    input  logic                   mc_issue,
    input  logic [ADDR_W-1:0]      mc_issue_addr,
    input  logic                   mc_valid,
    input  logic [ADDR_W-1:0]      mc_addr,
    input  logic [DATA_W-1:0]      mc_data,
    output logic                   mc_ready,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_addr,
    output logic [DATA_W-1:0]      rf_data,
    output logic [2**ADDR_W-1:0]   pending_mask,
    output logic                   stall_req
);

    import wb_pkg::*;

    localparam int unsigned NREG     = 2 ** ADDR_W;
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t              mc_entry, head;
    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                unused_count;

    logic                sel_we, bypass;
    logic [ADDR_W-1:0]   sel_addr, clr_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                clr_en;

    logic [NREG-1:0]     pend_q, pend_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                stall_q, stall_d;

    assign mc_entry     = '{addr: mc_addr, data: mc_data};
    assign unused_count = ^fifo_count;

    wb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (fifo_push),
        .wdata_i (mc_entry),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        fifo_pop = 1'b0;
        bypass   = 1'b0;
        if (pipe_we) begin
            sel_we   = 1'b1;
            sel_addr = pipe_addr;
            sel_data = pipe_data;
        end else if (!fifo_empty) begin
            sel_we   = 1'b1;
            sel_addr = head.addr;
            sel_data = head.data;
            fifo_pop = 1'b1;
        end
`ifdef WB_BYPASS_EN
        else if (mc_valid) begin
            sel_we   = 1'b1;
            sel_addr = mc_addr;
            sel_data = mc_data;
            bypass   = 1'b1;
        end
`endif
    end

    // Writes to the zero register are dropped, but the FIFO head still retires.
    assign rf_we     = sel_we && (sel_addr != ADDR_W'(REG_ZERO)) && !RST;
    assign rf_addr   = sel_addr;
    assign rf_data   = sel_data;
    assign mc_ready  = !fifo_full;
    assign fifo_push = mc_valid && !fifo_full && !bypass;

    assign clr_en   = fifo_pop || bypass;
    assign clr_addr = fifo_pop ? head.addr : mc_addr;

    // Issue is applied after retire so a same-cycle set of the same bit wins.
    always_comb begin
        pend_d = pend_q;
        if (clr_en) begin
            pend_d[clr_addr] = 1'b0;
        end
        if (mc_issue) begin
            pend_d[mc_issue_addr] = 1'b1;
        end
        pend_d[REG_ZERO] = 1'b0;
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_pop || fifo_empty) begin
            starve_d = '0;
        end else if (pipe_we && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + 1'b1;
        end
        stall_d = (starve_d == STARVE_W'(STARVE_LIMIT));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_q   <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign pending_mask = pend_q;
    assign stall_req    = stall_q;

endmodule

// File: tb/tb_wb_commit_arb.sv
// Directed plus randomized bench for wb_commit_arb against a queue-based reference model.
module tb_wb_commit_arb;

    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_addr = '0;
    logic [31:0] pipe_data = '0;
    logic        mc_issue = 1'b0;
    logic [4:0]  mc_issue_addr = '0;
    logic        mc_valid = 1'b0;
    logic [4:0]  mc_addr = '0;
    logic [31:0] mc_data = '0;
    logic        mc_ready, rf_we, stall_req;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [31:0] pending_mask;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [4:0]  q_addr[$];
    logic [31:0] q_data[$];
    logic [31:0] m_pend = '0;
    int          m_starve = 0;
    bit          m_stall = 0;
    bit          m_acc = 0;

    always #5 CLK = ~CLK;

    wb_commit_arb u_dut (
        .CLK           (CLK),
        .RST           (RST),
        .pipe_we       (pipe_we),
        .pipe_addr     (pipe_addr),
        .pipe_data     (pipe_data),
        .mc_issue      (mc_issue),
        .mc_issue_addr (mc_issue_addr),
        .mc_valid      (mc_valid),
        .mc_addr       (mc_addr),
        .mc_data       (mc_data),
        .mc_ready      (mc_ready),
        .rf_we         (rf_we),
        .rf_addr       (rf_addr),
        .rf_data       (rf_data),
        .pending_mask  (pending_mask),
        .stall_req     (stall_req)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit we, input int pa, input int pd, input bit iss, input int ia,
                         input bit v, input int ma, input int md);
        pipe_we       = we;
        pipe_addr     = 5'(pa);
        pipe_data     = 32'(pd);
        mc_issue      = iss;
        mc_issue_addr = 5'(ia);
        mc_valid      = v;
        mc_addr       = 5'(ma);
        mc_data       = 32'(md);
    endtask

    // Checks all outputs against the model mid-cycle, then advances the model at the edge.
    task automatic cycle();
        bit          sel, pop, byp, acc, rdy, exp_we;
        logic [4:0]  sa;
        logic [31:0] sd;
        int          pre_size;
        @(negedge CLK);
        rdy = (q_addr.size() < DEPTH);
        sel = 0; pop = 0; byp = 0; sa = '0; sd = '0;
        if (pipe_we) begin
            sel = 1; sa = pipe_addr; sd = pipe_data;
        end else if (q_addr.size() > 0) begin
            sel = 1; sa = q_addr[0]; sd = q_data[0]; pop = 1;
        end
`ifdef WB_BYPASS_EN
        else if (mc_valid) begin
            sel = 1; sa = mc_addr; sd = mc_data; byp = 1;
        end
`endif
        acc    = mc_valid && rdy;
        exp_we = sel && (sa != 0) && !RST;
        chk("rf_we", rf_we, exp_we);
        if (exp_we) begin
            chk("rf_addr", rf_addr, sa);
            chk("rf_data", rf_data, sd);
        end else if (!sel && !RST) begin
            chk("rf_addr_idle", rf_addr, 0);
            chk("rf_data_idle", rf_data, 0);
        end
        chk("mc_ready", mc_ready, rdy);
        chk("pending_mask", pending_mask, m_pend);
        chk("stall_req", stall_req, m_stall);
        @(posedge CLK);
        if (RST) begin
            q_addr.delete();
            q_data.delete();
            m_pend = '0; m_starve = 0; m_stall = 0; m_acc = 0;
        end else begin
            pre_size = q_addr.size();
            if (pop) begin
                m_pend[q_addr[0]] = 1'b0;
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
            end
            if (byp) m_pend[mc_addr] = 1'b0;
            if (acc && !byp) begin
                q_addr.push_back(mc_addr);
                q_data.push_back(mc_data);
            end
            if (mc_issue) m_pend[mc_issue_addr] = 1'b1;
            m_pend[0] = 1'b0;
            if (pop || pre_size == 0) m_starve = 0;
            else if (pipe_we && m_starve < LIMIT) m_starve++;
            m_stall = (m_starve >= LIMIT);
            m_acc   = acc;
        end
        #1;
    endtask

    initial begin
        logic [4:0]  iss[$];
        bit          offer_on;
        logic [31:0] offer_data;
        int          a;

        // Reset with a pipeline write pending on the inputs
        drive(1, 5, 32'h77, 0, 0, 0, 0, 0);
        @(posedge CLK); #1;
        cycle();
        cycle();
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_pending", pending_mask, 0);
        chk("rst_ready", mc_ready, 1);
        chk("rst_stall", stall_req, 0);
        RST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Pipeline priority over a buffered result
        drive(0, 0, 0, 1, 8, 0, 0, 0);
        cycle();
        drive(1, 3, 32'h11, 0, 0, 1, 8, 32'hDEAD_BEEF);
        #1; chk("prio_pipe1", rf_addr, 3);
        cycle();
        drive(1, 3, 32'h11, 0, 0, 0, 0, 0);
        #1; chk("prio_pipe2", rf_addr, 3);
        chk("prio_pend8_set", pending_mask[8], 1);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("prio_mc_addr", rf_addr, 8);
        chk("prio_mc_data", rf_data, 32'hDEAD_BEEF);
        cycle();
        #1; chk("prio_pend8_clr", pending_mask[8], 0);

        // Fill the FIFO while the pipeline owns the port
        for (int k = 1; k <= 5; k++) begin
            drive(1, 10, k + 32'h100, 1, k, 0, 0, 0);
            cycle();
        end
        for (int k = 1; k <= 4; k++) begin
            drive(1, 10, k + 32'h200, 0, 0, 1, k, k);
            cycle();
        end
        drive(0, 0, 0, 0, 0, 1, 5, 5);
        #1; chk("full_ready", mc_ready, 0);
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 0, 0, 0, k <= 2, 5, 5);
            #1; chk("drain_addr", rf_addr, k);
            chk("drain_data", rf_data, k);
            cycle();
        end

        // Starvation raises stall_req, which drops after the pop
        drive(0, 0, 0, 1, 12, 0, 0, 0);
        cycle();
        drive(1, 20, 32'h99, 0, 0, 1, 12, 32'hC0DE);
        cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1, 20, 32'h99, 0, 0, 0, 0, 0);
            #1; chk("starve_no_stall", stall_req, 0);
            cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("starve_stall", stall_req, 1);
        chk("starve_head", rf_addr, 12);
        cycle();
        #1; chk("starve_release", stall_req, 0);

        // Zero register is never written
        drive(1, 0, 32'h55, 0, 0, 1, 0, 32'hAA);
        #1; chk("zero_pipe_we", rf_we, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("zero_mc_we", rf_we, 0);
        cycle();
        #1; chk("zero_popped_addr", rf_addr, 0);
        chk("zero_pend0", pending_mask[0], 0);

        // Bypass path (or one-cycle buffer latency without it)
        drive(0, 0, 0, 1, 9, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 1, 9, 32'h1234);
`ifdef WB_BYPASS_EN
        #1; chk("byp_we", rf_we, 1);
        chk("byp_addr", rf_addr, 9);
        chk("byp_data", rf_data, 32'h1234);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("byp_pend9", pending_mask[9], 0);
        chk("byp_no_push", rf_we, 0);
        cycle();
`else
        #1; chk("buf_we0", rf_we, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("buf_we1", rf_we, 1);
        chk("buf_addr", rf_addr, 9);
        chk("buf_data", rf_data, 32'h1234);
        cycle();
`endif

        // Reset mid-operation discards buffered results
        drive(0, 0, 0, 1, 7, 0, 0, 0);
        cycle();
        drive(1, 4, 32'h4, 0, 0, 1, 7, 32'h7777);
        cycle();
        RST = 1'b1;
        drive(1, 4, 32'h4, 0, 0, 0, 0, 0);
        #1; chk("midrst_we", rf_we, 0);
        cycle();
        RST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("midrst_empty", rf_we, 0);
        chk("midrst_pend", pending_mask, 0);
        cycle();

        // Randomized traffic obeying the hazard-unit protocol
        offer_on   = 0;
        offer_data = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!offer_on && iss.size() > 0 && m_pend[iss[0]] && $urandom_range(0, 1) == 1) begin
                offer_on   = 1;
                offer_data = $urandom;
            end
            mc_valid = offer_on;
            mc_addr  = offer_on ? iss[0] : 5'($urandom_range(0, 31));
            mc_data  = offer_on ? offer_data : $urandom;

            mc_issue      = 1'b0;
            mc_issue_addr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) begin
                a = $urandom_range(1, 31);
                if (!m_pend[a] && !(a inside {iss})) begin
                    mc_issue      = 1'b1;
                    mc_issue_addr = 5'(a);
                    iss.push_back(5'(a));
                end
            end

            pipe_we   = 1'b0;
            pipe_addr = 5'($urandom_range(0, 31));
            pipe_data = $urandom;
            if (!m_stall && $urandom_range(0, 9) < 6 && !m_pend[pipe_addr]) pipe_we = 1'b1;

            cycle();
            if (offer_on && m_acc) begin
                void'(iss.pop_front());
                offer_on = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
